// File: rtl/ram_loader.sv
// ram_loader: streams len_m1+1 words into RAM at base_addr (wrapping mod 2**ADDR_W), reads them back and flags XOR-checksum mismatch on err; start/base_addr/len_m1 request, in_data/in_valid/in_ready stream, ram_* RAM port, busy/done/err status
module ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_csn,
  output logic              ram_rwn,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_CAPTURE, DONE} state_t;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  state_t state;
  logic [ADDR_W-1:0] base, len, ptr;
  logic [ADDR_W:0] remaining;
  logic [DATA_W-1:0] wsum, rsum;
  assign in_ready = state == WRITE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base <= '0;
      len <= '0;
      ptr <= '0;
      remaining <= '0;
      wsum <= '0;
      rsum <= '0;
      err <= 1'b0;
      ram_addr <= '0;
      ram_data_in <= '0;
      ram_csn <= 1'b1;
      ram_rwn <= 1'b1;
    end else begin
      ram_csn <= 1'b1;
      ram_rwn <= 1'b1;
      case (state)
        IDLE: if (start) begin
          base <= base_addr;
          len <= len_m1;
          ptr <= base_addr;
          remaining <= {1'b0, len_m1} + ONE;
          wsum <= '0;
          rsum <= '0;
          err <= 1'b0;
          state <= WRITE;
        end
        WRITE: if (in_valid) begin
          ram_csn <= 1'b0;
          ram_rwn <= 1'b0;
          ram_addr <= ptr;
          ram_data_in <= in_data;
          wsum <= wsum ^ in_data;
          ptr <= remaining == ONE ? base : ptr + 1'b1;
          remaining <= remaining == ONE ? {1'b0, len} + ONE : remaining - ONE;
          state <= remaining == ONE ? RD_ISSUE : WRITE;
        end
        RD_ISSUE: begin
          ram_csn <= 1'b0;
          ram_addr <= ptr;
          state <= RD_WAIT;
        end
        RD_WAIT: state <= RD_CAPTURE;
        RD_CAPTURE: begin
          rsum <= rsum ^ ram_data_out;
          ptr <= ptr + 1'b1;
          remaining <= remaining - ONE;
          state <= remaining == ONE ? DONE : RD_ISSUE;
        end
        DONE: begin
          err <= rsum != wsum;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized directed loads against a RAM model and a queue/array reference
module tb_ram_loader;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, mem_clr = 1, corrupt_en = 0;
  logic [3:0] base_addr = 0, len_m1 = 0, in_data = 0;
  logic in_ready, ram_csn, ram_rwn, busy, done, err;
  logic [3:0] ram_addr, ram_data_in, ram_data_out;
  logic [3:0] mem [16];
  logic [3:0] ref_mem [16];
  logic [3:0] wds [$];
  logic [7:0] wq [$];
  int cyc = 0, done_cnt = 0, passed = 0, failed = 0, total = 0;

  ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len_m1(len_m1),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_csn(ram_csn), .ram_rwn(ram_rwn),
    .ram_data_out(ram_data_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
    end else if (!ram_csn) begin
      if (!ram_rwn) mem[ram_addr] <= (corrupt_en && ram_addr == 4'd4) ? 4'h0 : ram_data_in;
      else ram_data_out <= mem[ram_addr];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ram_csn && !ram_rwn) wq.push_back({ram_addr, ram_data_in});
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_csn", ram_csn, 1);
    chk("rst_rwn", ram_rwn, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_data_in, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
  endtask

  task automatic load(input int b, input int lm1, input bit rnd, input bit bp,
                      input bit corrupt, input int abort_at, input bit noise);
    int n, idx, g, s, q0, d0, t0, a;
    logic [3:0] ws, rs;
    bit v, took;
    n = lm1 + 1; idx = 0; g = 0; s = 0; ws = 0; rs = 0;
    if (rnd) begin
      wds.delete();
      for (int i = 0; i < n; i++) wds.push_back(4'($urandom_range(0, 15)));
    end
    if (corrupt)
      for (int i = 0; i < n; i++) if ((b + i) % 16 == 4) wds[i] = wds[i] | 4'h1;
    q0 = wq.size();
    d0 = done_cnt;
    corrupt_en = corrupt;
    @(negedge clk);
    start = 1; base_addr = 4'(b); len_m1 = 4'(lm1); t0 = cyc;
    @(negedge clk);
    start = 0; base_addr = 4'($urandom);
    chk("busy_start", busy, 1);
    chk("err_clr", err, 0);
    while (idx < n && g < 400 && !(abort_at > 0 && idx == abort_at)) begin
      v = bp ? (s % 3 == 0) : 1'b1;
      s++; g++;
      in_valid = v;
      in_data = v ? wds[idx] : 4'($urandom);
      start = noise && s == 2;
      if (start) len_m1 = 4'($urandom);
      took = v && in_ready;
      @(negedge clk);
      if (took) idx++;
    end
    start = 0;
    chk("words_taken", idx, abort_at > 0 ? abort_at : n);
    for (int i = 0; i < idx; i++) begin
      a = (b + i) % 16;
      ref_mem[a] = (corrupt && a == 4) ? 4'h0 : wds[i];
    end
    if (abort_at > 0) begin
      rst = 1; in_valid = 0;
      @(negedge clk);
      rst = 0;
      reset_checks();
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_strobes", wq.size() - q0, idx);
      corrupt_en = 0;
      return;
    end
    in_valid = noise;
    g = 0;
    while (!done && g < 200) begin
      start = noise && g == 1;
      @(negedge clk);
      g++;
    end
    start = 0;
    chk("done_seen", done, 1);
    if (!bp) chk("latency", cyc - t0, 4 * n + 1);
    for (int i = 0; i < n; i++) begin
      ws ^= wds[i];
      rs ^= ref_mem[(b + i) % 16];
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("err", err, ws != rs);
    chk("busy_idle", busy, 0);
    repeat (3) @(negedge clk);
    chk("err_hold", err, ws != rs);
    chk("strobes", wq.size() - q0, n);
    for (int i = 0; i < n && q0 + i < wq.size(); i++)
      chk("wr_seq", wq[q0 + i], {4'((b + i) % 16), wds[i]});
    for (int i = 0; i < 16; i++) chk("mem", mem[i], ref_mem[i]);
    chk("done_cnt", done_cnt - d0, 1);
    in_valid = 0;
    corrupt_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 0; mem_clr = 0;
    @(negedge clk);
    reset_checks();
    wds = '{4'hA, 4'h5, 4'hF};
    load(3, 2, 0, 0, 0, 0, 0);
    wds.delete();
    for (int i = 0; i < 16; i++) wds.push_back(4'(i));
    load(8, 15, 0, 0, 0, 0, 0);
    load($urandom_range(0, 15), $urandom_range(3, 15), 1, 1, 0, 0, 0);
    load($urandom_range(0, 15), $urandom_range(0, 15), 1, 1, 0, 0, 0);
    load(2, 4, 1, 0, 1, 0, 0);
    load($urandom_range(0, 15), $urandom_range(0, 15), 1, 0, 0, 0, 0);
    load($urandom_range(0, 15), 4, 1, 0, 0, 2, 0);
    load($urandom_range(0, 15), $urandom_range(0, 15), 1, 0, 0, 0, 0);
    load(5, 3, 1, 0, 0, 0, 1);
    repeat (4) load($urandom_range(0, 15), $urandom_range(0, 15), 1, 1'($urandom_range(0, 1)), 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
